// File: rtl/maxpool_user_scheduler_if.sv
// Handshake bundle between the conv output, the scheduler and the maxpool engine.
// slave is the scheduler's view; master is the view of whatever drives it.
interface maxpool_user_scheduler_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 3,
    parameter int COL_W       = 10,
    parameter int BLK_W       = 10
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [COL_W-1:0]       cfg_cols_m1;
    logic [BLK_W-1:0]       cfg_blocks_m1;
    logic                   cfg_is_max;
    logic                   cfg_is_1x1;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [DATA_WIDTH-1:0]  s_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic [DATA_WIDTH-1:0]  m_axis_tdata;
    logic [TUSER_WIDTH-1:0] m_axis_tuser;
    logic                   m_axis_tlast;
    logic                   busy;

    modport slave (
        input  cfg_valid, cfg_cols_m1, cfg_blocks_m1, cfg_is_max, cfg_is_1x1,
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output cfg_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata,
        output m_axis_tuser, m_axis_tlast, busy
    );

    modport master (
        output cfg_valid, cfg_cols_m1, cfg_blocks_m1, cfg_is_max, cfg_is_1x1,
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  cfg_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata,
        input  m_axis_tuser, m_axis_tlast, busy
    );
endinterface

// File: rtl/maxpool_user_scheduler.sv
// Stamps maxpool window flags and layer tlast onto the conv output stream.
// One output register stage; column/block counters walk the configured layer.
module maxpool_user_scheduler #(
    parameter int UNITS        = 8,
    parameter int GROUPS       = 2,
    parameter int WORD_WIDTH   = 8,
    parameter int DATA_WIDTH   = GROUPS*UNITS*2*WORD_WIDTH,
    parameter int TUSER_WIDTH  = 3,
    parameter int I_IS_NOT_MAX = 0,
    parameter int I_IS_MAX     = 1,
    parameter int I_IS_1X1     = 2,
    parameter int COL_W        = 10,
    parameter int BLK_W        = 10
) (
    input logic aclk,
    input logic aresetn,
    maxpool_user_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [TUSER_WIDTH-1:0] user;
        logic                   last;
    } beat_t;

    state_t           state, state_n;
    logic [COL_W-1:0] col, cols_m1;
    logic [BLK_W-1:0] blk, blocks_m1;
    logic             is_max, is_1x1;
    beat_t            out_q, beat_n;
    logic             out_vld;
    logic             cfg_rdy, in_rdy;
    logic             cfg_hs, in_hs, out_hs, last_col, last_blk;

    assign last_col = (col == cols_m1);
    assign last_blk = (blk == blocks_m1);
    assign cfg_hs   = bus.cfg_valid && cfg_rdy;
    assign in_hs    = bus.s_axis_tvalid && in_rdy;
    assign out_hs   = out_vld && bus.m_axis_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_n;
    end

    // cfg_ready is gated by reset so nothing is offered while the block is held.
    always_comb begin
        state_n = state;
        cfg_rdy = 1'b0;
        in_rdy  = 1'b0;
        case (state)
            IDLE: begin
                cfg_rdy = aresetn;
                if (bus.cfg_valid && aresetn) state_n = RUN;
            end
            RUN: begin
                in_rdy = !out_vld || bus.m_axis_tready;
                if (bus.s_axis_tvalid && in_rdy && last_col && last_blk) state_n = DRAIN;
            end
            DRAIN: begin
                if (out_hs && out_q.last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The last column always closes a window, which covers odd widths.
    always_comb begin
        beat_n                    = '0;
        beat_n.data               = bus.s_axis_tdata;
        beat_n.user[I_IS_1X1]     = is_1x1;
        beat_n.user[I_IS_NOT_MAX] = !is_max;
        beat_n.user[I_IS_MAX]     = is_max && (col[0] || last_col);
        beat_n.last               = last_col && last_blk;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cols_m1   <= '0;
            blocks_m1 <= '0;
            is_max    <= 1'b0;
            is_1x1    <= 1'b0;
            col       <= '0;
            blk       <= '0;
        end else if (cfg_hs) begin
            cols_m1   <= bus.cfg_cols_m1;
            blocks_m1 <= bus.cfg_blocks_m1;
            is_max    <= bus.cfg_is_max;
            is_1x1    <= bus.cfg_is_1x1;
            col       <= '0;
            blk       <= '0;
        end else if (in_hs) begin
            if (last_col) begin
                col <= '0;
                blk <= blk + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (in_hs) begin
            out_vld <= 1'b1;
            out_q   <= beat_n;
        end else if (out_hs) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.cfg_ready     = cfg_rdy;
    assign bus.s_axis_tready = in_rdy;
    assign bus.m_axis_tvalid = out_vld;
    assign bus.m_axis_tdata  = out_q.data;
    assign bus.m_axis_tuser  = out_q.user;
    assign bus.m_axis_tlast  = out_q.last;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_maxpool_user_scheduler.sv
// Directed bench for maxpool_user_scheduler: hand-written tuser/tlast tables per layer,
// random payloads checked in order, plus reset, stall-hold and busy timing.
module tb_maxpool_user_scheduler;
    localparam int DW = 2*8*2*8;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    maxpool_user_scheduler_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(3), .COL_W(10), .BLK_W(10)) bus();

    maxpool_user_scheduler #(
        .UNITS(8), .GROUPS(2), .WORD_WIDTH(8), .TUSER_WIDTH(3), .COL_W(10), .BLK_W(10)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] exp_d[$], got_d[$];
    logic [2:0]    exp_u[$], got_u[$];
    logic          exp_l[$], got_l[$];

    logic          in_acc, cfg_acc, busy_s, cfgr_s, rnd_rdy;
    logic          hold_p;
    logic [DW-1:0] hold_d;
    logic [2:0]    hold_u;
    int            stall_in;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Snapshot taken on the falling edge; inputs only change just after the rising edge.
    task automatic mon();
        in_acc  = bus.s_axis_tvalid && bus.s_axis_tready;
        cfg_acc = bus.cfg_valid && bus.cfg_ready;
        busy_s  = bus.busy;
        cfgr_s  = bus.cfg_ready;
        if (bus.s_axis_tvalid && !bus.s_axis_tready) stall_in++;
        if (bus.m_axis_tvalid && hold_p) begin
            chk("hold_data", bus.m_axis_tdata, hold_d);
            chk("hold_user", DW'(bus.m_axis_tuser), DW'(hold_u));
        end
        hold_p = bus.m_axis_tvalid && !bus.m_axis_tready;
        hold_d = bus.m_axis_tdata;
        hold_u = bus.m_axis_tuser;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            got_d.push_back(bus.m_axis_tdata);
            got_u.push_back(bus.m_axis_tuser);
            got_l.push_back(bus.m_axis_tlast);
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        mon();
        @(posedge aclk);
        #1;
        if (rnd_rdy) bus.m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    // Runs one layer; abort>0 stops after that many accepted input beats and skips checks.
    task automatic run_layer(input int c, input int b, input logic mx, input logic x1,
                             input logic rnd, input int abort);
        int n, idx, guard;
        logic [DW-1:0] d;
        n = (c + 1) * (b + 1);
        exp_d.delete();
        got_d.delete(); got_u.delete(); got_l.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
            exp_d.push_back(d);
        end
        bus.cfg_cols_m1   = 10'(c);
        bus.cfg_blocks_m1 = 10'(b);
        bus.cfg_is_max    = mx;
        bus.cfg_is_1x1    = x1;
        bus.cfg_valid     = 1'b1;
        rnd_rdy           = rnd;
        bus.m_axis_tready = 1'b1;
        guard = 0;
        cfg_acc = 1'b0;
        while (!cfg_acc && guard < 50) begin
            cycle();
            guard++;
        end
        if (!cfg_acc) chk("cfg_timeout", DW'(0), DW'(1));
        bus.cfg_valid     = 1'b0;
        idx               = 0;
        stall_in          = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = exp_d[0];
        guard = 0;
        while (got_d.size() < n && guard < 2000 && !(abort > 0 && idx >= abort)) begin
            cycle();
            guard++;
            if (in_acc && idx < n) begin
                idx++;
                if (idx < n) bus.s_axis_tdata = exp_d[idx];
                else         bus.s_axis_tvalid = 1'b0;
            end
        end
        if (abort > 0) begin
            chk("abort_reached", DW'(idx), DW'(abort));
            return;
        end
        rnd_rdy = 1'b0;
        bus.m_axis_tready = 1'b1;
        chk("beats", DW'(got_d.size()), DW'(n));
        for (int i = 0; i < n && i < got_d.size() && i < exp_u.size(); i++) begin
            chk($sformatf("data%0d", i), got_d[i], exp_d[i]);
            chk($sformatf("user%0d", i), DW'(got_u[i]), DW'(exp_u[i]));
            chk($sformatf("last%0d", i), DW'(got_l[i]), DW'(exp_l[i]));
        end
        chk("busy_last", DW'(busy_s), DW'(1));
        cycle();
        chk("busy_drop", DW'(busy_s), DW'(0));
        chk("cfg_ready_back", DW'(cfgr_s), DW'(1));
    endtask

    task automatic set_exp(input logic [2:0] u, input logic l);
        exp_u.push_back(u);
        exp_l.push_back(l);
    endtask

    initial begin
        hold_p = 1'b0; hold_d = '0; hold_u = '0; rnd_rdy = 1'b0; stall_in = 0;
        in_acc = 1'b0; cfg_acc = 1'b0; busy_s = 1'b0; cfgr_s = 1'b0;
        bus.cfg_cols_m1 = '0; bus.cfg_blocks_m1 = '0; bus.cfg_is_max = 1'b0; bus.cfg_is_1x1 = 1'b0;

        // Reset with traffic offered on every input
        aresetn           = 1'b0;
        bus.cfg_valid     = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = {DW/32{32'hA5A5_5A5A}};
        bus.m_axis_tready = 1'b1;
        repeat (3) cycle();
        chk("rst_cfg_ready", DW'(bus.cfg_ready), DW'(0));
        chk("rst_s_tready", DW'(bus.s_axis_tready), DW'(0));
        chk("rst_m_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
        chk("rst_m_tdata", bus.m_axis_tdata, DW'(0));
        chk("rst_m_tuser", DW'(bus.m_axis_tuser), DW'(0));
        chk("rst_m_tlast", DW'(bus.m_axis_tlast), DW'(0));
        chk("rst_busy", DW'(bus.busy), DW'(0));
        bus.cfg_valid     = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        aresetn           = 1'b1;
        #1;
        chk("rel_cfg_ready", DW'(bus.cfg_ready), DW'(1));
        chk("rel_s_tready", DW'(bus.s_axis_tready), DW'(0));
        cycle();

        // Passthrough, 4 columns x 2 blocks, 1x1 kernel
        exp_u.delete(); exp_l.delete();
        for (int i = 0; i < 8; i++) set_exp(3'b101, i == 7);
        run_layer(3, 1, 1'b0, 1'b1, 1'b0, 0);
        chk("pass_stalls", DW'(stall_in), DW'(0));

        // Pooling, even width
        exp_u.delete(); exp_l.delete();
        set_exp(3'b000, 1'b0); set_exp(3'b010, 1'b0);
        set_exp(3'b000, 1'b0); set_exp(3'b010, 1'b1);
        run_layer(3, 0, 1'b1, 1'b0, 1'b0, 0);

        // Pooling, odd width: last column closes a partial window
        exp_u.delete(); exp_l.delete();
        set_exp(3'b000, 1'b0); set_exp(3'b010, 1'b0); set_exp(3'b010, 1'b0);
        set_exp(3'b000, 1'b0); set_exp(3'b010, 1'b0); set_exp(3'b010, 1'b1);
        run_layer(2, 1, 1'b1, 1'b0, 1'b0, 0);

        // Backpressure on a 16-beat pooled 1x1 layer
        exp_u.delete(); exp_l.delete();
        for (int i = 0; i < 16; i++) set_exp((i % 2) ? 3'b110 : 3'b100, i == 15);
        run_layer(7, 1, 1'b1, 1'b1, 1'b1, 0);

        // Mid-layer reset after beat 3 of 8
        exp_u.delete(); exp_l.delete();
        run_layer(3, 1, 1'b0, 1'b0, 1'b0, 3);
        chk("pre_rst_vld", DW'(bus.m_axis_tvalid), DW'(1));
        aresetn = 1'b0;
        #1;
        chk("mid_rst_vld", DW'(bus.m_axis_tvalid), DW'(0));
        chk("mid_rst_busy", DW'(bus.busy), DW'(0));
        chk("mid_rst_s_tready", DW'(bus.s_axis_tready), DW'(0));
        chk("mid_rst_tlast", DW'(bus.m_axis_tlast), DW'(0));
        bus.s_axis_tvalid = 1'b0;
        repeat (2) cycle();
        aresetn = 1'b1;
        cycle();

        // Degenerate single-beat layer after the reset
        exp_u.delete(); exp_l.delete();
        set_exp(3'b010, 1'b1);
        run_layer(0, 0, 1'b1, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
